dmem_arb: RTL

DMEM_ARB -- requirements
Module: dmem_arb

---
 rtl/dmem_arb.sv | 119 +++++++++++
 1 files changed

// File: rtl/dmem_arb.sv
// dmem_arb: two-master round-robin arbiter in front of a single-port data memory.
// Master 0 is the core LSU, master 1 is DMA/debug. Grants are combinational,
// load data returns one cycle after the grant on the granted master's rdata.
module dmem_arb #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             m0_req,
  input  logic             m0_we,
  input  logic             m0_worb,
  input  logic [WIDTH-1:0] m0_addr,
  input  logic [WIDTH-1:0] m0_wdata,
  output logic             m0_gnt,
  output logic             m0_rvalid,
  output logic [WIDTH-1:0] m0_rdata,

  input  logic             m1_req,
  input  logic             m1_we,
  input  logic             m1_worb,
  input  logic [WIDTH-1:0] m1_addr,
  input  logic [WIDTH-1:0] m1_wdata,
  output logic             m1_gnt,
  output logic             m1_rvalid,
  output logic [WIDTH-1:0] m1_rdata,

  output logic             mem_we,
  output logic             mem_worb,
  output logic [WIDTH-1:0] mem_a,
  output logic [WIDTH-1:0] mem_wd,
  input  logic [WIDTH-1:0] mem_rd
);

  // last_gnt_q = index of the most recently granted master; 1 after reset so
  // master 0 wins the first contention.
  logic             last_gnt_q, last_gnt_d;
  logic             m0_rvalid_q, m0_rvalid_d;
  logic             m1_rvalid_q, m1_rvalid_d;
  logic [WIDTH-1:0] m0_rdata_q, m0_rdata_d;
  logic [WIDTH-1:0] m1_rdata_q, m1_rdata_d;
  logic             gnt0, gnt1;

  // Grant selection: single requester wins outright, contention goes round-robin.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (m0_req && m1_req) begin
        if (last_gnt_q) gnt0 = 1'b1;
        else            gnt1 = 1'b1;
      end else if (m0_req) begin
        gnt0 = 1'b1;
      end else if (m1_req) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign m0_gnt = gnt0;
  assign m1_gnt = gnt1;

  // Memory-side mux; with no grant the port parks on master 0 with writes off.
  always_comb begin
    mem_we   = 1'b0;
    mem_worb = 1'b0;
    mem_a    = m0_addr;
    mem_wd   = m0_wdata;
    if (gnt1) begin
      mem_we   = m1_we;
      mem_worb = m1_worb;
      mem_a    = m1_addr;
      mem_wd   = m1_wdata;
    end else if (gnt0) begin
      mem_we   = m0_we;
      mem_worb = m0_worb;
      mem_a    = m0_addr;
      mem_wd   = m0_wdata;
    end
  end

  // Next-state: round-robin pointer and per-master load response capture.
  always_comb begin
    last_gnt_d  = last_gnt_q;
    m0_rvalid_d = gnt0 && !m0_we;
    m1_rvalid_d = gnt1 && !m1_we;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;
    if (gnt0) last_gnt_d = 1'b0;
    if (gnt1) last_gnt_d = 1'b1;
    if (gnt0 && !m0_we) m0_rdata_d = mem_rd;
    if (gnt1 && !m1_we) m1_rdata_d = mem_rd;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt_q  <= 1'b1;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      last_gnt_q  <= last_gnt_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  // Responses are masked while reset is high so a load granted just before
  // reset never shows up, even in the cycle before the flops clear.
  assign m0_rvalid = m0_rvalid_q && !reset;
  assign m1_rvalid = m1_rvalid_q && !reset;
  assign m0_rdata  = reset ? '0 : m0_rdata_q;
  assign m1_rdata  = reset ? '0 : m1_rdata_q;

endmodule
